// File: rtl/gpu_pkg.sv
// Shared encodings and widths for the core scheduler, the instruction fetcher and the program-memory channel.
package gpu_pkg;

    localparam int PROGRAM_MEM_ADDR_BITS = 8;
    localparam int PROGRAM_MEM_DATA_BITS = 16;
    localparam int CACHE_LINES           = 8;

    typedef enum logic [2:0] {
        CORE_IDLE   = 3'b000,
        CORE_FETCH  = 3'b001,
        CORE_DECODE = 3'b010,
        CORE_DONE   = 3'b111
    } core_state_e;

    typedef enum logic [2:0] {
        FETCHER_IDLE     = 3'b000,
        FETCHER_FETCHING = 3'b001,
        FETCHER_FETCHED  = 3'b010
    } fetcher_state_e;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped instruction cache storage: one word per line, combinational read port,
// synchronous write port, async clear on reset and synchronous flush of all valid bits.
module icache_array #(
    parameter int LINES  = 8,
    parameter int IDX_W  = 3,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic              o_rd_valid,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [DATA_W-1:0] i_wr_data
);

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES];

    // Valid bits: flush wins over a same-cycle install.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Tag and data storage, written on a line fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LINES; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/fetcher_icache.sv
// Instruction fetcher for one core: answers the scheduler's FETCH phase from a small
// direct-mapped cache, falling back to a program-memory read on a miss.
module fetcher_icache
    import gpu_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = gpu_pkg::PROGRAM_MEM_ADDR_BITS,
    parameter int PROGRAM_MEM_DATA_BITS = gpu_pkg::PROGRAM_MEM_DATA_BITS,
    parameter int CACHE_LINES           = gpu_pkg::CACHE_LINES
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic                             cache_hit
);

    localparam int IDX_W = $clog2(CACHE_LINES);
    localparam int TAG_W = PROGRAM_MEM_ADDR_BITS - IDX_W;

    fetcher_state_e                     r_state, w_state_nxt;
    logic                               r_valid, w_valid_nxt;
    logic [PROGRAM_MEM_ADDR_BITS-1:0]   r_addr, w_addr_nxt;
    logic [PROGRAM_MEM_DATA_BITS-1:0]   r_instr, w_instr_nxt;
    logic                               r_hit, w_hit_nxt;
    logic                               r_drop, w_drop_nxt;
    logic                               w_wr_en;
    logic                               w_rd_valid;
    logic [TAG_W-1:0]                   w_rd_tag;
    logic [PROGRAM_MEM_DATA_BITS-1:0]   w_rd_data;
    logic                               w_fetch_req;
    logic                               w_hit;

    icache_array #(
        .LINES  (CACHE_LINES),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (PROGRAM_MEM_DATA_BITS)
    ) u_array (
        .clk        (clk),
        .rst_n      (reset),
        .i_flush    (flush),
        .i_rd_idx   (current_pc[IDX_W-1:0]),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (r_addr[IDX_W-1:0]),
        .i_wr_tag   (r_addr[PROGRAM_MEM_ADDR_BITS-1:IDX_W]),
        .i_wr_data  (mem_read_data)
    );

    assign w_fetch_req = (core_state == CORE_FETCH);
    assign w_hit       = w_rd_valid && (w_rd_tag == current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX_W]);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FETCHER_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a fill in flight always completes even if the scheduler moves on.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCHER_IDLE: begin
                if (w_fetch_req) begin
                    w_state_nxt = w_hit ? FETCHER_FETCHED : FETCHER_FETCHING;
                end else begin
                    w_state_nxt = FETCHER_IDLE;
                end
            end
            FETCHER_FETCHING: begin
                if (mem_read_ready) begin
                    w_state_nxt = FETCHER_FETCHED;
                end else begin
                    w_state_nxt = FETCHER_FETCHING;
                end
            end
            FETCHER_FETCHED: begin
                if (core_state == CORE_DECODE) begin
                    w_state_nxt = FETCHER_IDLE;
                end else begin
                    w_state_nxt = FETCHER_FETCHED;
                end
            end
            default: w_state_nxt = FETCHER_IDLE;
        endcase
    end

    // Output/datapath next values; a flush seen at any point of a fill suppresses the install.
    always_comb begin
        w_valid_nxt = r_valid;
        w_addr_nxt  = r_addr;
        w_instr_nxt = r_instr;
        w_hit_nxt   = 1'b0;
        w_drop_nxt  = 1'b0;
        w_wr_en     = 1'b0;
        case (r_state)
            FETCHER_IDLE: begin
                if (w_fetch_req && w_hit) begin
                    w_instr_nxt = w_rd_data;
                    w_hit_nxt   = 1'b1;
                end else if (w_fetch_req) begin
                    w_valid_nxt = 1'b1;
                    w_addr_nxt  = current_pc;
                end else begin
                    w_valid_nxt = 1'b0;
                end
            end
            FETCHER_FETCHING: begin
                if (mem_read_ready) begin
                    w_valid_nxt = 1'b0;
                    w_instr_nxt = mem_read_data;
                    w_wr_en     = !(r_drop || flush);
                end else begin
                    w_drop_nxt  = r_drop || flush;
                end
            end
            FETCHER_FETCHED: w_valid_nxt = 1'b0;
            default:         w_valid_nxt = 1'b0;
        endcase
    end

    // Registered outputs and drop flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_instr <= '0;
            r_hit   <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_valid <= w_valid_nxt;
            r_addr  <= w_addr_nxt;
            r_instr <= w_instr_nxt;
            r_hit   <= w_hit_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    assign mem_read_valid   = r_valid;
    assign mem_read_address = r_addr;
    assign fetcher_state    = r_state;
    assign instruction      = r_instr;
    assign cache_hit        = r_hit;

endmodule
